// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, shifts
// out byte/parity/stop on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 240,
  parameter int unsigned TIMEOUT_CYCLES = 32000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_REL} state_t;

  state_t        state, state_n;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          clk_s, data_s, fall, expired;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [9:0]    frame, frame_n;
  logic          data_bit, data_bit_n;
  logic          done_n, error_n;

  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign fall    = ~clk_s & clk_prev;
  assign expired = ~fall && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      data_bit  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= clk_s;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      frame     <= frame_n;
      data_bit  <= data_bit_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    frame_n     = frame;
    data_bit_n  = data_bit;
    done_n      = 1'b0;
    error_n     = 1'b0;
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          // frame shifts out LSB first: data[0..7], odd parity, stop
          frame_n = {1'b1, ~^tx_data, tx_data};
          cnt_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (cnt == INH_LAST);
        if (cnt == INH_LAST) begin
          cnt_n   = '0;
          state_n = START;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      START: begin
        ps2_data_oe = 1'b1;
        cnt_n       = '0;
        bit_cnt_n   = '0;
        data_bit_n  = 1'b0;
        state_n     = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = ~data_bit;
        if (fall) begin
          data_bit_n = frame[0];
          frame_n    = {1'b1, frame[9:1]};
          bit_cnt_n  = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (data_s) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared watchdog: cnt holds cycles since the last device falling edge;
    // expiry overrides any done so the two pulses stay exclusive.
    if (state == SHIFT || state == ACK || state == WAIT_REL) begin
      cnt_n = fall ? CW'(1) : cnt + CW'(1);
      if (expired) begin
        done_n  = 1'b0;
        error_n = 1'b1;
        state_n = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame out, a scoreboard queue holds the expected frame and outcome per byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH = 240;
  localparam int unsigned TO  = 1500;
  localparam int unsigned H   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // open-collector bus: either side can pull a line low
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .done(done), .error(error)
  );

  typedef struct { logic [7:0] data; logic par; logic ack; } vec_t;
  typedef struct { logic [9:0] frame; logic exp_done; logic exp_err; } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int done_total = 0, err_total = 0, both_cnt = 0, wide = 0, ready_bad = 0;
  int exp_done_total = 0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (done && error) both_cnt++;
    if (done) done_total++;
    if (error) err_total++;
    if ((done && done_prev) || (error && err_prev)) wide++;
    if (done && !tx_ready) ready_bad++;
    done_prev = done;
    err_prev  = error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] d, input string tag);
    int n_clk, n_dat;
    logic last_dat;
    @(negedge clk);
    check({tag, " ready"}, tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    n_clk = 0; n_dat = 0; last_dat = 1'b0;
    while (ps2_clk_oe && n_clk < int'(INH) + 10) begin
      n_clk++;
      if (ps2_data_oe) n_dat++;
      last_dat = ps2_data_oe;
      @(negedge clk);
    end
    check({tag, " inhibit_len"}, n_clk, INH);
    check({tag, " inhibit_data_cycles"}, n_dat, 1);
    check({tag, " inhibit_data_last"}, last_dat, 1);
    check({tag, " start_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task automatic dev_clocks(input int n, input int poke, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      dev_clk = 1'b0;
      if (i == poke) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cycles(H - 1);
      end else begin
        cycles(H);
      end
      bits[i]  = ps2_data_in;
      dev_clk  = 1'b1;
      cycles(H);
    end
  endtask

  task automatic dev_ack(input logic ack);
    dev_data = ack ? 1'b0 : 1'b1;
    cycles(3);
    dev_clk = 1'b0;
    cycles(H);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic full_xfer(input vec_t v, input int poke, input string tag);
    logic [9:0] bits;
    int d0, e0, n;
    exp_t e;
    sb.push_back('{frame: {1'b1, v.par, v.data}, exp_done: v.ack, exp_err: !v.ack});
    if (v.ack) exp_done_total++;
    d0 = done_total;
    e0 = err_total;
    accept(v.data, tag);
    cycles(5);
    dev_clocks(10, poke, bits);
    dev_ack(v.ack);
    n = 0;
    while (done_total == d0 && err_total == e0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cycles(3);
    e = sb.pop_front();
    check({tag, " frame"}, bits, e.frame);
    check({tag, " done"}, done_total - d0, e.exp_done);
    check({tag, " error"}, err_total - e0, e.exp_err);
    check({tag, " released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check({tag, " ready_after"}, tx_ready, 1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [9:0] bits;
    int d0, e0, n;
    vecs[0] = '{data: 8'hF4, par: 1'b0, ack: 1'b1};
    vecs[1] = '{data: 8'hED, par: 1'b1, ack: 1'b1};
    vecs[2] = '{data: 8'h00, par: 1'b1, ack: 1'b1};
    vecs[3] = '{data: 8'h01, par: 1'b0, ack: 1'b1};
    vecs[4] = '{data: 8'h80, par: 1'b0, ack: 1'b1};
    vecs[5] = '{data: 8'h3C, par: 1'b1, ack: 1'b0};

    cycles(3);
    check("reset ready", tx_ready, 1);
    check("reset oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset pulses", {done, error}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    // device clock activity while idle must be ignored
    e0 = err_total;
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; cycles(H);
      dev_clk = 1'b1; cycles(H);
    end
    check("idle_falls ready", tx_ready, 1);
    check("idle_falls oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("idle_falls error", err_total - e0, 0);

    for (int i = 0; i < 6; i++) full_xfer(vecs[i], -1, $sformatf("vec%0d", i));

    // second request mid-SHIFT must not disturb the byte in flight
    full_xfer('{data: 8'hC3, par: 1'b1, ack: 1'b1}, 4, "busy_poke");

    // device stalls after 4 falling edges
    d0 = done_total;
    e0 = err_total;
    accept(8'h5A, "timeout");
    cycles(5);
    dev_clocks(3, -1, bits);
    dev_clk = 1'b0;
    n = 0;
    while (n < int'(TO) + 50) begin
      @(negedge clk);
      n++;
      if (n == int'(H)) dev_clk = 1'b1;
      if (error) break;
    end
    // two synchronizer stages sit between the line and the edge detector
    check("timeout latency", n, TO + 2);
    check("timeout released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    dev_clk = 1'b1;
    cycles(5);
    check("timeout error count", err_total - e0, 1);
    check("timeout done count", done_total - d0, 0);

    // reset in the middle of SHIFT
    accept(8'hA5, "midreset");
    cycles(5);
    dev_clocks(3, -1, bits);
    dev_clk = 1'b0;
    cycles(4);
    d0 = done_total;
    e0 = err_total;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("midreset ready", tx_ready, 1);
    check("midreset pulses", {done, error}, 2'b00);
    reset = 1'b0;
    dev_clk = 1'b1;
    cycles(30);
    check("midreset no_pulse", (done_total - d0) + (err_total - e0), 0);
    full_xfer('{data: 8'hFF, par: 1'b1, ack: 1'b1}, -1, "after_reset");

    check("pulse exclusive", both_cnt, 0);
    check("pulse width", wide, 0);
    check("ready with done", ready_bad, 0);
    check("done total", done_total, exp_done_total);
    check("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 240, clk cycles the PS/2 clock is held low before the start bit (120 us at 2 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32000, max clk cycles between device clock falling edges before abort (16 ms at 2 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  high when idle and able to accept a byte.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-009 SHALL have port ps2_data_in  input  1  raw PS/2 data line level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release (open collector).
REQ-011 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 SHALL have port done  output  1  one-cycle pulse: byte sent and device acknowledged.
REQ-013 SHALL have port error  output  1  one-cycle pulse: NACK or timeout.

Function
REQ-014 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers; a falling edge is synced clk low while the previous synced sample was high.
REQ-015 SHALL accept a byte on tx_valid && tx_ready, latch tx_data, and compute odd parity (parity bit = XNOR-reduce of the byte).
REQ-016 SHALL implement states IDLE, INHIBIT, START, SHIFT, ACK, WAIT_REL.
REQ-017 IDLE: tx_ready=1, both oe=0; tx_valid while busy is ignored, and tx_data is not re-sampled.
REQ-018 INHIBIT: entered the cycle after acceptance; ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe=1 during the final INHIBIT cycle.
REQ-019 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); the bit counter and timeout counter clear; next state is SHIFT.
REQ-020 SHIFT: on each device-clock falling edge, drive the next bit: data bits 0..7 LSB first, then parity, then stop (ps2_data_oe=0); ps2_data_oe = ~bit.
REQ-021 SHIFT: after the 10th falling edge (stop released), go to ACK.
REQ-022 ACK: on the next falling edge, sample synced data; 0 -> WAIT_REL; 1 -> error pulse, IDLE.
REQ-023 WAIT_REL: wait for both synced lines high, then pulse done and return to IDLE; tx_ready=1 in the same cycle as done.
REQ-024 SHALL reset the timeout counter on every falling edge in START/SHIFT/ACK/WAIT_REL; on reaching TIMEOUT_CYCLES, release both lines, pulse error, go to IDLE.
REQ-025 done and error SHALL never assert in the same cycle; each is exactly 1 cycle wide.
REQ-026 Falling edges seen in IDLE or INHIBIT SHALL be ignored (device traffic is the receiver's concern).
REQ-027 Counters SHALL be sized to hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap.

Reset
REQ-028 Reset SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, done=0, error=0, and clear counters, synchronizer flops (to 1) and the latched byte.
REQ-029 Reset asserted mid-transfer SHALL release both lines on the next clk edge, with no done/error pulse.

Verification
REQ-030 tx_data=0xF4 with a device model ACKing -> clk_oe high for 240 cycles; data bits 0,0,1,0,1,1,1,1; parity 0; stop released; done pulses once.
REQ-031 tx_data=0xED -> parity bit 1 (popcount 6); done pulses; tx_ready=1 afterwards.
REQ-032 Device holds data high in the ACK slot -> error pulses once; done stays 0; both oe=0.
REQ-033 Device stops clocking after 4 bits -> error exactly TIMEOUT_CYCLES after the last falling edge; lines released.
REQ-034 tx_valid pulsed again during SHIFT with 0x00 -> ignored; original byte completes unchanged.
REQ-035 Reset asserted during SHIFT -> next cycle both oe=0, tx_ready=1, no done/error; a subsequent 0xFF (parity 1) transfer succeeds.
